float_reader: RTL

- Read-side companion to the `float` storage register. It samples a `float_pkg::float_t` word on request, decodes it into sign, unbiased exponent, significand and IEEE-754 class, and returns the result over a valid/ready handshake.
- Two-stage pipeline (capture, decode) with full backpressure and a saturating NaN counter. Sits between `float.data_q` and any consumer of decoded values.

---
 rtl/float_reader.sv | 116 +++++++++++
 1 files changed

// File: rtl/float_reader.sv
// Decodes float words into sign/exponent/significand/class; 2-cycle capture+decode pipeline.
// Valid/ready handshake with full backpressure, at most 2 items in flight, FIFO order.
module float_reader #(
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  output logic               req_ready_o,
  input  logic [31:0]        data_i,
  output logic               rvalid_o,
  input  logic               rready_i,
  output logic               rsign_o,
  output logic [8:0]         rexp_o,
  output logic [23:0]        rsig_o,
  output logic [2:0]         rclass_o,
  output logic [COUNT_W-1:0] nan_count_o
);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float_t;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_SUB    = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_QNAN   = 3'd4,
    CLS_SNAN   = 3'd5
  } cls_e;

  // Two's complement -126, the fixed exponent of every subnormal.
  localparam logic [8:0] EXP_SUB = 9'h182;

  float_t      raw_q;
  logic        raw_valid_q;
  logic        adv;
  logic        accept;
  logic        deliver;
  logic        out_is_nan;

  logic        d_sign;
  logic [8:0]  d_exp;
  logic [23:0] d_sig;
  cls_e        d_class;

  assign adv         = raw_valid_q && (!rvalid_o || rready_i);
  assign req_ready_o = !raw_valid_q || adv;
  assign accept      = req_i && req_ready_o;
  assign deliver     = rvalid_o && rready_i;
  assign out_is_nan  = (rclass_o == CLS_QNAN) || (rclass_o == CLS_SNAN);

  always_comb begin
    d_sign  = raw_q.sign;
    d_exp   = '0;
    d_sig   = '0;
    d_class = CLS_ZERO;
    if (raw_q.exp == 8'd0) begin
      if (raw_q.man != '0) begin
        d_class = CLS_SUB;
        d_exp   = EXP_SUB;
        d_sig   = {1'b0, raw_q.man};
      end
    end else if (raw_q.exp == 8'hFF) begin
      if (raw_q.man == '0) begin
        d_class = CLS_INF;
      end else begin
        d_class = raw_q.man[22] ? CLS_QNAN : CLS_SNAN;
        d_sig   = {1'b0, raw_q.man};
      end
    end else begin
      d_class = CLS_NORMAL;
      d_exp   = {1'b0, raw_q.exp} - 9'd127;
      d_sig   = {1'b1, raw_q.man};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raw_q       <= '0;
      raw_valid_q <= 1'b0;
      rvalid_o    <= 1'b0;
      rsign_o     <= 1'b0;
      rexp_o      <= '0;
      rsig_o      <= '0;
      rclass_o    <= '0;
      nan_count_o <= '0;
    end else begin
      if (accept) begin
        raw_q       <= data_i;
        raw_valid_q <= 1'b1;
      end else if (adv) begin
        raw_valid_q <= 1'b0;
      end

      if (adv) begin
        rvalid_o <= 1'b1;
        rsign_o  <= d_sign;
        rexp_o   <= d_exp;
        rsig_o   <= d_sig;
        rclass_o <= d_class;
      end else if (deliver) begin
        rvalid_o <= 1'b0;
      end

      // Counts results actually handed off, so a stalled NaN waits for its handshake.
      if (deliver && out_is_nan && (nan_count_o != {COUNT_W{1'b1}})) begin
        nan_count_o <= nan_count_o + COUNT_W'(1);
      end
    end
  end

endmodule
